// File: rtl/score_bcd_multiplex_if.sv
// Bus between the game FSM, the score/strobe block and the 7-segment driver.
// The game FSM side is the master; the score block is the slave.
interface score_bcd_multiplex_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  localparam int unsigned SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    TARGET_ATE;
  logic [3:0]              POINTS;
  logic                    GAME_OVER;
  logic                    CLEAR;
  logic                    SHOW_HIGH;
  logic [SEL_W-1:0]        STROBE_COUNT;
  logic [3:0]              SCORE_COUNT;
  logic                    DIGIT_BLANK;
  logic [4*NUM_DIGITS-1:0] SCORE_BCD;
  logic [4*NUM_DIGITS-1:0] HIGH_BCD;
  logic                    SATURATED;

  modport master (
    output TARGET_ATE, POINTS, GAME_OVER, CLEAR, SHOW_HIGH,
    input  STROBE_COUNT, SCORE_COUNT, DIGIT_BLANK, SCORE_BCD, HIGH_BCD, SATURATED
  );

  modport slave (
    input  TARGET_ATE, POINTS, GAME_OVER, CLEAR, SHOW_HIGH,
    output STROBE_COUNT, SCORE_COUNT, DIGIT_BLANK, SCORE_BCD, HIGH_BCD, SATURATED
  );
endinterface

// File: rtl/score_bcd_multiplex.sv
// N-digit saturating BCD score with high-score register and a strobed,
// leading-zero-blanked digit output for a multiplexed 7-segment display.
module score_bcd_multiplex #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned STROBE_DIV = 100000
) (
  input logic                   CLK,
  input logic                   RESET,
  score_bcd_multiplex_if.slave  bus
);
  localparam int unsigned SEL_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PRE_W   = $clog2(STROBE_DIV);
  localparam int unsigned SCORE_W = 4 * NUM_DIGITS;

  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [SEL_W-1:0]   strobe_q, strobe_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic               sat_q, sat_d;

  logic [3:0]         addend;
  logic [4:0]         dig_sum;
  logic               carry;
  logic [SCORE_W-1:0] sum_bcd;
  logic [SCORE_W-1:0] src;
  logic [3:0]         digit;
  logic               upper_zero;

  // Decimal ripple add of the clamped points value into the live score.
  always_comb begin
    addend  = (bus.POINTS > 4'd9) ? 4'd9 : bus.POINTS;
    carry   = 1'b0;
    dig_sum = '0;
    sum_bcd = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      dig_sum = {1'b0, score_q[4*k +: 4]} + {1'b0, ((k == 0) ? addend : 4'd0)} + {4'd0, carry};
      if (dig_sum > 5'd9) begin
        sum_bcd[4*k +: 4] = 4'(dig_sum - 5'd10);
        carry             = 1'b1;
      end else begin
        sum_bcd[4*k +: 4] = dig_sum[3:0];
        carry             = 1'b0;
      end
    end
  end

  always_comb begin
    score_d  = score_q;
    sat_d    = sat_q;
    high_d   = high_q;
    pre_d    = pre_q + 1'b1;
    strobe_d = strobe_q;

    // Compare against the registered score so a same-cycle add or clear is not seen.
    if (bus.GAME_OVER && (score_q > high_q)) begin
      high_d = score_q;
    end

    if (bus.CLEAR) begin
      score_d = '0;
      sat_d   = 1'b0;
    end else if (bus.TARGET_ATE) begin
      if (carry) begin
        score_d = {NUM_DIGITS{4'h9}};
        sat_d   = 1'b1;
      end else begin
        score_d = sum_bcd;
      end
    end

    if (pre_q == PRE_W'(STROBE_DIV - 1)) begin
      pre_d    = '0;
      strobe_d = (strobe_q == SEL_W'(NUM_DIGITS - 1)) ? '0 : strobe_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pre_q    <= '0;
      strobe_q <= '0;
      score_q  <= '0;
      high_q   <= '0;
      sat_q    <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      strobe_q <= strobe_d;
      score_q  <= score_d;
      high_q   <= high_d;
      sat_q    <= sat_d;
    end
  end

  // Digit select plus leading-zero detection over the selected digit and everything above.
  always_comb begin
    src        = bus.SHOW_HIGH ? high_q : score_q;
    digit      = '0;
    upper_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (strobe_q == SEL_W'(k)) begin
        digit = src[4*k +: 4];
      end
      if ((SEL_W'(k) >= strobe_q) && (src[4*k +: 4] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end
  end

  assign bus.STROBE_COUNT = strobe_q;
  assign bus.SCORE_COUNT  = digit;
  assign bus.DIGIT_BLANK  = (strobe_q != '0) && upper_zero;
  assign bus.SCORE_BCD    = score_q;
  assign bus.HIGH_BCD     = high_q;
  assign bus.SATURATED    = sat_q;

endmodule

// File: tb/tb_score_bcd_multiplex.sv
// Bench for score_bcd_multiplex: a 4-digit/div-4 instance and a 3-digit/div-2 instance,
// checked against a decimal-integer model and a table of expected values.
module tb_score_bcd_multiplex;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edges;
  int   checks = 0;
  int   errors = 0;

  int   m_score = 0;
  int   m_high  = 0;
  logic m_sat   = 1'b0;

  typedef struct {
    string       name;
    logic        tgt;
    logic [3:0]  pts;
    logic        go;
    logic        clr;
    logic [15:0] score;
    logic [15:0] high;
    logic        sat;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] score;
    logic [15:0] high;
    logic        sat;
  } exp_t;

  exp_t sb[$];

  score_bcd_multiplex_if #(.NUM_DIGITS(4)) b1 ();
  score_bcd_multiplex_if #(.NUM_DIGITS(3)) b2 ();

  score_bcd_multiplex #(.NUM_DIGITS(4), .STROBE_DIV(4)) u_dut4 (
    .CLK  (clk),
    .RESET(rst),
    .bus  (b1.slave)
  );

  score_bcd_multiplex #(.NUM_DIGITS(3), .STROBE_DIV(2)) u_dut3 (
    .CLK  (clk),
    .RESET(rst),
    .bus  (b2.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int d;
    r = '0;
    d = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(d % 10);
      d = d / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic tgt, input logic [3:0] pts, input logic go,
                            input logic clr);
    int p;
    if (go && (m_score > m_high)) m_high = m_score;
    if (clr) begin
      m_score = 0;
      m_sat   = 1'b0;
    end else if (tgt) begin
      p = (pts > 4'd9) ? 9 : int'(pts);
      if (m_score + p > 9999) begin
        m_score = 9999;
        m_sat   = 1'b1;
      end else begin
        m_score = m_score + p;
      end
    end
  endtask

  task automatic drive_cycle(input logic tgt, input logic [3:0] pts, input logic go,
                             input logic clr);
    b1.TARGET_ATE = tgt;
    b1.POINTS     = pts;
    b1.GAME_OVER  = go;
    b1.CLEAR      = clr;
    @(posedge clk);
    #1;
    b1.TARGET_ATE = 1'b0;
    b1.POINTS     = 4'd0;
    b1.GAME_OVER  = 1'b0;
    b1.CLEAR      = 1'b0;
  endtask

  task automatic step(input logic tgt, input logic [3:0] pts, input logic go, input logic clr);
    model_step(tgt, pts, go, clr);
    drive_cycle(tgt, pts, go, clr);
  endtask

  task automatic drive_to(input int target);
    while (m_score + 9 <= target) step(1'b1, 4'd9, 1'b0, 1'b0);
    if (m_score < target) step(1'b1, 4'(target - m_score), 1'b0, 1'b0);
  endtask

  task automatic run_checked(input string name, input logic tgt, input logic [3:0] pts,
                             input logic go, input logic clr);
    exp_t e;
    model_step(tgt, pts, go, clr);
    sb.push_back('{name, to_bcd(m_score), to_bcd(m_high), m_sat});
    drive_cycle(tgt, pts, go, clr);
    e = sb.pop_front();
    check({e.name, ".score"}, b1.SCORE_BCD, e.score);
    check({e.name, ".high"}, b1.HIGH_BCD, e.high);
    check({e.name, ".sat"}, {15'd0, b1.SATURATED}, {15'd0, e.sat});
  endtask

  task automatic check_display(input string name, input logic [15:0] val, input int cycles);
    int idx;
    logic [15:0] upper;
    #1;
    for (int i = 0; i < cycles; i++) begin
      idx   = (edges / 4) % 4;
      upper = val >> (4 * idx);
      check({name, ".strobe"}, 16'(b1.STROBE_COUNT), 16'(idx));
      check({name, ".digit"}, 16'(b1.SCORE_COUNT), upper & 16'h000f);
      check({name, ".blank"}, {15'd0, b1.DIGIT_BLANK},
            {15'd0, (idx != 0) && (upper == 16'h0000)});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    m_score = 0;
    m_high  = 0;
    m_sat   = 1'b0;
  endtask

  initial begin
    vec_t tbl[15];
    exp_t e;
    int   idx2;

    tbl[0]  = '{"add8",       1'b1, 4'd8,  1'b0, 1'b0, 16'h0008, 16'h0000, 1'b0};
    tbl[1]  = '{"add5",       1'b1, 4'd5,  1'b0, 1'b0, 16'h0013, 16'h0000, 1'b0};
    tbl[2]  = '{"add12",      1'b1, 4'd12, 1'b0, 1'b0, 16'h0022, 16'h0000, 1'b0};
    tbl[3]  = '{"add0",       1'b1, 4'd0,  1'b0, 1'b0, 16'h0022, 16'h0000, 1'b0};
    tbl[4]  = '{"go22",       1'b0, 4'd0,  1'b1, 1'b0, 16'h0022, 16'h0022, 1'b0};
    tbl[5]  = '{"go_equal",   1'b0, 4'd0,  1'b1, 1'b0, 16'h0022, 16'h0022, 1'b0};
    tbl[6]  = '{"clr_tgt",    1'b1, 4'd9,  1'b0, 1'b1, 16'h0000, 16'h0022, 1'b0};
    tbl[7]  = '{"go_lower",   1'b1, 4'd9,  1'b1, 1'b0, 16'h0009, 16'h0022, 1'b0};
    tbl[8]  = '{"add15",      1'b1, 4'd15, 1'b0, 1'b0, 16'h0018, 16'h0022, 1'b0};
    tbl[9]  = '{"go_clr_low", 1'b0, 4'd0,  1'b1, 1'b1, 16'h0000, 16'h0022, 1'b0};
    tbl[10] = '{"add9a",      1'b1, 4'd9,  1'b0, 1'b0, 16'h0009, 16'h0022, 1'b0};
    tbl[11] = '{"add9b",      1'b1, 4'd9,  1'b0, 1'b0, 16'h0018, 16'h0022, 1'b0};
    tbl[12] = '{"add9c",      1'b1, 4'd9,  1'b0, 1'b0, 16'h0027, 16'h0022, 1'b0};
    tbl[13] = '{"go_clr_hi",  1'b0, 4'd0,  1'b1, 1'b1, 16'h0000, 16'h0027, 1'b0};
    tbl[14] = '{"go_zero",    1'b0, 4'd0,  1'b1, 1'b0, 16'h0000, 16'h0027, 1'b0};

    b1.TARGET_ATE = 1'b0; b1.POINTS = 4'd0; b1.GAME_OVER = 1'b0; b1.CLEAR = 1'b0;
    b1.SHOW_HIGH  = 1'b0;
    b2.TARGET_ATE = 1'b0; b2.POINTS = 4'd0; b2.GAME_OVER = 1'b0; b2.CLEAR = 1'b0;
    b2.SHOW_HIGH  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset mid-count with a live score and high score.
    #1;
    check("reset.score", b1.SCORE_BCD, 16'h0000);
    check("reset.strobe", 16'(b1.STROBE_COUNT), 16'h0000);
    drive_to(42);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.score", b1.SCORE_BCD, 16'h0000);
    check("async_rst.high", b1.HIGH_BCD, 16'h0000);
    check("async_rst.sat", {15'd0, b1.SATURATED}, 16'h0000);
    check("async_rst.strobe", 16'(b1.STROBE_COUNT), 16'h0000);
    check("async_rst.digit", 16'(b1.SCORE_COUNT), 16'h0000);
    check("async_rst.blank", {15'd0, b1.DIGIT_BLANK}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    m_score = 0; m_high = 0; m_sat = 1'b0;

    // Strobed display of the live score, then of a zero high score.
    drive_to(42);
    check("build42", b1.SCORE_BCD, 16'h0042);
    check_display("live42", 16'h0042, 16);
    b1.SHOW_HIGH = 1'b1;
    check_display("high0", 16'h0000, 16);
    b1.SHOW_HIGH = 1'b0;

    // Table of single-cycle operations from a fresh reset.
    pulse_reset();
    for (int i = 0; i < 15; i++) begin
      sb.push_back('{tbl[i].name, tbl[i].score, tbl[i].high, tbl[i].sat});
      drive_cycle(tbl[i].tgt, tbl[i].pts, tbl[i].go, tbl[i].clr);
      e = sb.pop_front();
      check({e.name, ".score"}, b1.SCORE_BCD, e.score);
      check({e.name, ".high"}, b1.HIGH_BCD, e.high);
      check({e.name, ".sat"}, {15'd0, b1.SATURATED}, {15'd0, e.sat});
    end
    m_score = 0; m_high = 27; m_sat = 1'b0;

    // High-score capture uses the pre-add value.
    drive_to(120);
    run_checked("go120", 1'b0, 4'd0, 1'b1, 1'b0);
    drive_to(137);
    run_checked("go_add3", 1'b1, 4'd3, 1'b1, 1'b0);
    run_checked("go140", 1'b0, 4'd0, 1'b1, 1'b0);
    run_checked("go140_eq", 1'b0, 4'd0, 1'b1, 1'b0);

    // Saturation at 9999 and clear.
    run_checked("clr", 1'b0, 4'd0, 1'b0, 1'b1);
    drive_to(9995);
    run_checked("sat_add7", 1'b1, 4'd7, 1'b0, 1'b0);
    run_checked("sat_hold", 1'b1, 4'd4, 1'b0, 1'b0);
    run_checked("sat_add0", 1'b1, 4'd0, 1'b0, 1'b0);
    run_checked("sat_clr", 1'b0, 4'd0, 1'b0, 1'b1);
    b1.SHOW_HIGH = 1'b1;
    check_display("high140", 16'h0140, 8);
    b1.SHOW_HIGH = 1'b0;

    // 3-digit instance: strobe wraps at 2 and the score saturates at 999.
    for (int i = 0; i < 12; i++) begin
      idx2 = (edges / 2) % 3;
      check("d3.strobe", 16'(b2.STROBE_COUNT), 16'(idx2));
      check("d3.blank", {15'd0, b2.DIGIT_BLANK}, {15'd0, idx2 != 0});
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 111; i++) begin
      b2.TARGET_ATE = 1'b1;
      b2.POINTS     = 4'd9;
      @(posedge clk);
      #1;
    end
    b2.TARGET_ATE = 1'b0;
    check("d3.999", {4'h0, b2.SCORE_BCD}, 16'h0999);
    check("d3.999_sat", {15'd0, b2.SATURATED}, 16'h0000);
    b2.TARGET_ATE = 1'b1;
    b2.POINTS     = 4'd1;
    @(posedge clk);
    #1;
    b2.TARGET_ATE = 1'b0;
    check("d3.ovf", {4'h0, b2.SCORE_BCD}, 16'h0999);
    check("d3.ovf_sat", {15'd0, b2.SATURATED}, 16'h0001);
    b2.CLEAR = 1'b1;
    @(posedge clk);
    #1;
    b2.CLEAR = 1'b0;
    check("d3.clr", {4'h0, b2.SCORE_BCD}, 16'h0000);
    check("d3.clr_sat", {15'd0, b2.SATURATED}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
